// File: rtl/sram_axi_slave.sv
// sram_axi_slave
//   AXI4 slave that terminates one interconnect slave port onto a single-port
//   synchronous SRAM macro. One read or write burst is serviced at a time; the
//   SRAM is sequenced beat by beat and R/B responses are returned.
//
// Ports
//   ACLK, ARESETn              clock, asynchronous active-low reset
//   AW*/W*/B*                  AXI write address / data / response channels
//   AR*/R*                     AXI read address / data channels
//   CS, OE, WEB, A, DI         SRAM chip select, output enable, byte write
//                              enables (active low), word address, write data
//   DO                         SRAM read data, valid the cycle after a read edge
//                              and held until the next access
module sram_axi_slave #(
  parameter int IDW  = 8,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 4,
  parameter int SAW  = 14
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // write address
  input  logic [IDW-1:0]    AWID,
  input  logic [AW-1:0]     AWADDR,
  input  logic [LENW-1:0]   AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  // write data
  input  logic [DW-1:0]     WDATA,
  input  logic [DW/8-1:0]   WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  // write response
  output logic [IDW-1:0]    BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  // read address
  input  logic [IDW-1:0]    ARID,
  input  logic [AW-1:0]     ARADDR,
  input  logic [LENW-1:0]   ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  // read data
  output logic [IDW-1:0]    RID,
  output logic [DW-1:0]     RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  // SRAM
  output logic              CS,
  output logic              OE,
  output logic [DW/8-1:0]   WEB,
  output logic [SAW-1:0]    A,
  output logic [DW-1:0]     DI,
  input  logic [DW-1:0]     DO
);

  localparam int SW = DW / 8;
  localparam logic [SAW-1:0]  ONE_A = SAW'(1);
  localparam logic [LENW-1:0] ONE_L = LENW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_DATA = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            last_grant_wr;   // 1 when the most recent grant went to write
  logic [LENW-1:0] cnt;
  logic            err;
  logic [IDW-1:0]  id_q;
  logic [SAW-1:0]  addr_q;
  logic [LENW-1:0] len_q;
  logic [1:0]      burst_q;

  logic            ar_grant, aw_grant, w_hs, r_hs, b_hs, beat_last;
  logic [SAW-1:0]  addr_step;

  // Size and the address bits outside the SRAM word range carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{AWSIZE, ARSIZE, AWADDR[AW-1:SAW+2], AWADDR[1:0],
                         ARADDR[AW-1:SAW+2], ARADDR[1:0]};

  // Round-robin between the two address channels: on contention the channel
  // that did not win last time is granted, so at most one READY is ever high.
  assign ar_grant  = (state == S_IDLE) && ARVALID && (!AWVALID || last_grant_wr);
  assign aw_grant  = (state == S_IDLE) && AWVALID && !ar_grant;
  assign w_hs      = (state == S_WR_DATA) && WVALID;
  assign r_hs      = (state == S_RD_DATA) && RREADY;
  assign b_hs      = (state == S_WR_RESP) && BREADY;
  assign beat_last = (cnt == len_q);
  // FIXED holds the address; INCR and WRAP both step one word, rolling over
  // naturally at the top of the SRAM word space.
  assign addr_step = (burst_q == 2'b00) ? addr_q : addr_q + ONE_A;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= S_IDLE;
      last_grant_wr <= 1'b1;
      cnt           <= '0;
      err           <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ar_grant) last_grant_wr <= 1'b0;
      if (aw_grant) last_grant_wr <= 1'b1;
      if (ar_grant || aw_grant) cnt <= '0;
      else if (w_hs || (r_hs && !beat_last)) cnt <= cnt + ONE_L;
      if (aw_grant) err <= 1'b0;
      else if (w_hs && (WLAST != beat_last)) err <= 1'b1;
    end
  end

  // Burst context; only meaningful while a burst is active, so no reset.
  always_ff @(posedge ACLK) begin
    if (ar_grant) begin
      id_q    <= ARID;
      addr_q  <= ARADDR[SAW+1:2];
      len_q   <= ARLEN;
      burst_q <= ARBURST;
    end else if (aw_grant) begin
      id_q    <= AWID;
      addr_q  <= AWADDR[SAW+1:2];
      len_q   <= AWLEN;
      burst_q <= AWBURST;
    end else if (w_hs || (r_hs && !beat_last)) begin
      addr_q  <= addr_step;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (ar_grant)      state_nxt = S_RD_ADDR;
        else if (aw_grant) state_nxt = S_WR_DATA;
      end
      S_RD_ADDR: state_nxt = S_RD_DATA;
      S_RD_DATA: if (r_hs) state_nxt = beat_last ? S_IDLE : S_RD_ADDR;
      // The burst ends at whichever comes first: WLAST or the final counted beat.
      S_WR_DATA: if (w_hs && (WLAST || beat_last)) state_nxt = S_WR_RESP;
      S_WR_RESP: if (b_hs) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = ar_grant;
    AWREADY = aw_grant;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BID     = '0;
    BRESP   = 2'b00;
    RVALID  = 1'b0;
    RID     = '0;
    RDATA   = '0;
    RRESP   = 2'b00;
    RLAST   = 1'b0;
    CS      = 1'b0;
    OE      = 1'b0;
    WEB     = {SW{1'b1}};
    A       = '0;
    DI      = '0;
    case (state)
      S_RD_ADDR: begin
        CS = 1'b1;
        OE = 1'b1;
        A  = addr_q;
      end
      S_RD_DATA: begin
        // Keep the read asserted at the same address so DO stays stable
        // while the master stalls.
        CS     = 1'b1;
        OE     = 1'b1;
        A      = addr_q;
        RVALID = 1'b1;
        RDATA  = DO;
        RID    = id_q;
        RLAST  = beat_last;
      end
      S_WR_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          CS  = 1'b1;
          WEB = ~WSTRB;
          A   = addr_q;
          DI  = WDATA;
        end
      end
      S_WR_RESP: begin
        BVALID = 1'b1;
        BID    = id_q;
        BRESP  = err ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
module tb_sram_axi_slave;
  localparam int IDW = 8, AW = 32, DW = 32, LENW = 4, SAW = 14;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic            ARESETn;
  logic [IDW-1:0]  AWID, ARID, BID, RID;
  logic [AW-1:0]   AWADDR, ARADDR;
  logic [LENW-1:0] AWLEN, ARLEN;
  logic [2:0]      AWSIZE, ARSIZE;
  logic [1:0]      AWBURST, ARBURST, BRESP, RRESP;
  logic            AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic            ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0]   WDATA, RDATA, DI, DO;
  logic [3:0]      WSTRB, WEB;
  logic            CS, OE;
  logic [SAW-1:0]  A;

  sram_axi_slave #(.IDW(IDW), .AW(AW), .DW(DW), .LENW(LENW), .SAW(SAW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  // Behavioural SRAM with a preload port used while the DUT is in reset.
  logic [DW-1:0]  mem [0:(1<<SAW)-1];
  logic           pre_we;
  logic [SAW-1:0] pre_a;
  logic [DW-1:0]  pre_d;
  initial DO = '0;
  always @(posedge ACLK) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (CS) begin
      if (OE && (&WEB)) DO <= mem[A];
      else for (int b = 0; b < 4; b++) if (!WEB[b]) mem[A][b*8 +: 8] <= DI[b*8 +: 8];
    end
  end

  typedef struct packed { logic [7:0] id; logic [31:0] data; logic last; logic [1:0] resp; } rexp_t;
  typedef struct packed { logic [7:0] id; logic [1:0] resp; } bexp_t;
  typedef struct packed { logic [13:0] a; logic [3:0] web; logic [31:0] di; } wexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  wexp_t wq[$];
  logic  gq[$];   // expected grant order: 0 = read, 1 = write

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor / scoreboard
  logic          prev_stall = 1'b0;
  logic [31:0]   prev_rdata = '0;
  always @(negedge ACLK) begin
    if (!ARESETn) prev_stall = 1'b0;
    else begin
      chk("one_ready", {62'd0, ARREADY, AWREADY} == 64'd3, 64'd0);
      if (ARVALID && ARREADY) begin
        if (gq.size() == 0) chk("unexp_ar_grant", 1, 0);
        else chk("grant_order_rd", gq.pop_front(), 0);
      end
      if (AWVALID && AWREADY) begin
        if (gq.size() == 0) chk("unexp_aw_grant", 1, 0);
        else chk("grant_order_wr", gq.pop_front(), 1);
      end
      if (RVALID && prev_stall) chk("rdata_stable", RDATA, prev_rdata);
      if (RVALID && RREADY) begin
        if (rq.size() == 0) chk("unexp_rbeat", 1, 0);
        else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rbeat", {RID, RDATA, RLAST, RRESP}, e);
        end
      end
      if (CS && (WEB != 4'hF)) begin
        if (wq.size() == 0) chk("unexp_sram_write", 1, 0);
        else begin
          wexp_t e;
          e = wq.pop_front();
          chk("sram_write", {A, WEB, DI}, e);
        end
      end
      if (BVALID && BREADY) begin
        if (bq.size() == 0) chk("unexp_bresp", 1, 0);
        else begin
          bexp_t e;
          e = bq.pop_front();
          chk("bresp", {BID, BRESP}, e);
        end
      end
      prev_stall = RVALID && !RREADY;
      prev_rdata = RDATA;
    end
  end

  // which: 0 ARREADY, 1 AWREADY, 2 WREADY, 3 RVALID, 4 BVALID
  task automatic wait_sig(input int which, input string nm);
    int  t;
    bit  ok;
    t = 0; ok = 0;
    while (t < 200) begin
      @(negedge ACLK);
      if ((which == 0 && ARREADY) || (which == 1 && AWREADY) || (which == 2 && WREADY) ||
          (which == 3 && RVALID) || (which == 4 && BVALID)) begin
        ok = 1;
        break;
      end
      t++;
    end
    if (!ok) chk({"timeout_", nm}, 1, 0);
  endtask

  task automatic preload(input logic [SAW-1:0] a, input logic [31:0] d);
    pre_we = 1; pre_a = a; pre_d = d;
    @(posedge ACLK); #1;
    pre_we = 0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input int stall, input bit push_g);
    if (push_g) gq.push_back(1'b0);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = 2'b01; ARVALID = 1;
    wait_sig(0, "arready");
    @(posedge ACLK); #1;
    ARVALID = 0;
    for (int b = 0; b <= int'(len); b++) begin
      RREADY = (stall == 0);
      wait_sig(3, "rvalid");
      if (stall > 0) begin
        repeat (stall) @(posedge ACLK);
        #1 RREADY = 1;
        @(negedge ACLK);
      end
      @(posedge ACLK); #1;
    end
    RREADY = 1;
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int nbeats, input logic [3:0] strb, input logic [31:0] d0,
                          input bit push_g);
    if (push_g) gq.push_back(1'b1);
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = 2'b01; AWVALID = 1;
    wait_sig(1, "awready");
    @(posedge ACLK); #1;
    AWVALID = 0;
    for (int b = 0; b < nbeats; b++) begin
      WDATA = d0 + 32'(b); WSTRB = strb; WLAST = (b == nbeats - 1); WVALID = 1;
      wait_sig(2, "wready");
      @(posedge ACLK); #1;
    end
    WVALID = 0; WLAST = 0;
    wait_sig(4, "bvalid");
    @(posedge ACLK); #1;
  endtask

  initial begin
    ARESETn = 0;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 0;
    WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 1;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 0; RREADY = 1;
    pre_we = 0; pre_a = 0; pre_d = 0;

    preload(14'd4, 32'hA0); preload(14'd5, 32'hA1);
    preload(14'd6, 32'hA2); preload(14'd7, 32'hA3);
    preload(14'd8, 32'hFFFFFFFF);

    // reset state
    #1;
    chk("rst_valid_ready", {ARREADY, AWREADY, WREADY, BVALID, RVALID}, 0);
    chk("rst_sram", {CS, OE, WEB, A, DI}, {1'b0, 1'b0, 4'hF, 14'd0, 32'd0});
    chk("rst_resp", {RID, RDATA, RLAST, RRESP, BID, BRESP}, 0);
    @(negedge ACLK);
    ARESETn = 1;
    @(posedge ACLK); #1;

    // 4-beat burst read of words 4..7
    for (int i = 0; i < 4; i++) rq.push_back({8'h15, 32'hA0 + 32'(i), (i == 3), 2'b00});
    do_read(8'h15, 32'h10, 4'd3, 0, 1);

    // single read with RREADY held low for 5 cycles
    rq.push_back({8'h16, 32'hA3, 1'b1, 2'b00});
    do_read(8'h16, 32'h1C, 4'd0, 5, 1);

    // partial-strobe write then readback
    wq.push_back({14'd8, 4'b1010, 32'h11223344});
    bq.push_back({8'h21, 2'b00});
    do_write(8'h21, 32'h20, 4'd0, 1, 4'b0101, 32'h11223344, 1);

    // simultaneous AR/AW, twice: read wins each time after a write
    for (int k = 0; k < 2; k++) begin
      gq.push_back(1'b0); gq.push_back(1'b1);
      rq.push_back({8'h33, (k == 0) ? 32'hA1 : 32'hA2, 1'b1, 2'b00});
      wq.push_back({14'd16 + 14'(k), 4'h0, 32'hCAFE0000 + 32'(k)});
      bq.push_back({8'h44, 2'b00});
      fork
        do_read(8'h33, (k == 0) ? 32'h14 : 32'h18, 4'd0, 0, 0);
        do_write(8'h44, 32'h40 + 32'(4 * k), 4'd0, 1, 4'hF, 32'hCAFE0000 + 32'(k), 0);
      join
    end

    rq.push_back({8'h22, 32'hFF22FF44, 1'b1, 2'b00});
    do_read(8'h22, 32'h20, 4'd0, 0, 1);

    // early WLAST: LEN=3 but only 2 beats -> SLVERR
    wq.push_back({14'd32, 4'h0, 32'hE0000000});
    wq.push_back({14'd33, 4'h0, 32'hE0000001});
    bq.push_back({8'h55, 2'b10});
    do_write(8'h55, 32'h80, 4'd3, 2, 4'hF, 32'hE0000000, 1);

    // INCR wrapping at the top of the word space
    wq.push_back({14'h3FFF, 4'h0, 32'h12340000});
    wq.push_back({14'h0000, 4'h0, 32'h12340001});
    bq.push_back({8'h66, 2'b00});
    do_write(8'h66, 32'hFFFC, 4'd1, 2, 4'hF, 32'h12340000, 1);
    rq.push_back({8'h67, 32'h12340000, 1'b0, 2'b00});
    rq.push_back({8'h67, 32'h12340001, 1'b1, 2'b00});
    do_read(8'h67, 32'hFFFC, 4'd1, 0, 1);

    // reset asserted during beat 2 of a 4-beat read
    gq.push_back(1'b0);
    rq.push_back({8'h77, 32'hA0, 1'b0, 2'b00});
    ARID = 8'h77; ARADDR = 32'h10; ARLEN = 4'd3; ARVALID = 1;
    wait_sig(0, "arready_rst");
    @(posedge ACLK); #1;
    ARVALID = 0;
    wait_sig(3, "rvalid_b1");
    @(posedge ACLK); #1;
    RREADY = 0;
    wait_sig(3, "rvalid_b2");
    #1 ARESETn = 0;
    #1;
    chk("midrst_rvalid", RVALID, 0);
    chk("midrst_cs", {CS, OE}, 0);
    @(posedge ACLK); #1;
    ARESETn = 1;
    RREADY = 1;
    @(posedge ACLK); #1;
    rq.push_back({8'h78, 32'hA3, 1'b1, 2'b00});
    do_read(8'h78, 32'h1C, 4'd0, 0, 1);

    repeat (5) @(posedge ACLK);
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    chk("gq_empty", gq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
